instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 138 +++++++++++++
 tb/tb_instr_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction loader: walks program memory from a start address, validates headers
// and streams headers/arguments into a downstream FIFO, always closing with STOP.
module instr_loader #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   fifo_full,
    output logic                   fifo_wr,
    output logic [INSTR_WIDTH-1:0] fifo_data,
    output logic [ADDR_WIDTH:0]    word_count
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, PUSH, TERM, FIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] word;
    logic [1:0]             arg_cnt;
    logic                   stop_pend;

    function automatic logic legal_op(input logic [5:0] op);
        case (op)
            6'h01, 6'h02, 6'h03, 6'h05, 6'h06, 6'h07: legal_op = 1'b1;
            default:                                   legal_op = 1'b0;
        endcase
    endfunction

    // The write strobe is qualified by the live fifo_full so a write never lands on a full FIFO.
    assign fifo_wr   = ((state == PUSH) || (state == TERM)) && !fifo_full;
    assign fifo_data = (state == PUSH) ? word : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            word_count <= '0;
            word       <= '0;
            arg_cnt    <= 2'd0;
            stop_pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mem_addr   <= start_addr;
                        word_count <= '0;
                        error      <= 1'b0;
                        arg_cnt    <= 2'd0;
                        stop_pend  <= 1'b0;
                        busy       <= 1'b1;
                        mem_rd     <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    mem_rd <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    word  <= mem_data;
                    state <= CHECK;
                end
                CHECK: begin
                    if (arg_cnt != 2'd0) begin
                        // Argument words are passed through without inspection.
                        arg_cnt   <= arg_cnt - 2'd1;
                        stop_pend <= 1'b0;
                        state     <= PUSH;
                    end else begin
                        arg_cnt <= word[1:0];
                        if (word == '0) begin
                            stop_pend <= 1'b1;
                            state     <= PUSH;
                        end else if (legal_op(word[7:2])) begin
                            stop_pend <= 1'b0;
                            state     <= PUSH;
                        end else begin
                            error <= 1'b1;
                            state <= TERM;
                        end
                    end
                end
                PUSH: begin
                    if (!fifo_full) begin
                        word_count <= word_count + CNT_ONE;
                        if (stop_pend) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else if (mem_addr == '1) begin
                            // Running off the top of memory without a STOP is a fault.
                            error <= 1'b1;
                            state <= TERM;
                        end else begin
                            mem_addr <= mem_addr + ADDR_ONE;
                            mem_rd   <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                TERM: begin
                    if (!fifo_full) begin
                        word_count <= word_count + CNT_ONE;
                        done       <= 1'b1;
                        state      <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: memory model, FIFO monitor and hand-computed expectations.
module tb_instr_loader;

    localparam int IW = 16;
    localparam int AW = 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          done;
    logic          error;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_data;
    logic          fifo_full;
    logic          fifo_wr;
    logic [IW-1:0] fifo_data;
    logic [AW:0]   word_count;

    instr_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_data  (fifo_data),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    logic [IW-1:0] wr_q [$];
    logic [AW-1:0] rd_q [$];
    int done_cnt  = 0;
    int full_viol = 0;
    int done_base = 0;
    int viol_base = 0;
    int checks    = 0;
    int errors    = 0;

    always @(negedge clk) begin
        if (fifo_wr) begin
            wr_q.push_back(fifo_data);
            if (fifo_full) full_viol++;
        end
        if (done) done_cnt++;
        if (mem_rd) rd_q.push_back(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        done_base = done_cnt;
        viol_base = full_viol;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (wr_q.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("write_wait", (wr_q.size() >= n), 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == done_base && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen", (done_cnt != done_base), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_prog1(input string tag);
        logic [IW-1:0] exp [6];
        exp = '{16'h000D, 16'h0005, 16'h000D, 16'h0007, 16'h0014, 16'h0000};
        chk({tag, "_nwr"}, wr_q.size(), 6);
        for (int i = 0; i < 6; i++) chk({tag, "_wr"}, wr_q[i], exp[i]);
        chk({tag, "_wcnt"}, word_count, 6);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_done"}, done_cnt - done_base, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fullwr"}, full_viol - viol_base, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_fifo_wr"}, fifo_wr, 0);
        chk({tag, "_fifo_data"}, fifo_data, 0);
        chk({tag, "_wcnt"}, word_count, 0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        fifo_full  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        #3;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Basic program with free-flowing FIFO
        mem[0] = 16'h000D; mem[1] = 16'h0005; mem[2] = 16'h000D;
        mem[3] = 16'h0007; mem[4] = 16'h0014; mem[5] = 16'h0000;
        clear_mon();
        pulse_start(8'h00);
        wait_done(200);
        check_prog1("prog1");
        chk("prog1_nrd", rd_q.size(), 6);

        // Stall the third write for ten cycles
        clear_mon();
        pulse_start(8'h00);
        wait_writes(2, 100);
        @(posedge clk); #1;
        fifo_full = 1'b1;
        repeat (10) @(posedge clk);
        chk("stall_nwr", wr_q.size(), 2);
        chk("stall_busy", busy, 1);
        #1 fifo_full = 1'b0;
        wait_done(200);
        check_prog1("stall");

        // Illegal opcode after one instruction
        mem[0] = 16'h000D; mem[1] = 16'h0003; mem[2] = 16'h0020;
        clear_mon();
        pulse_start(8'h00);
        wait_done(200);
        chk("bad_nwr", wr_q.size(), 3);
        chk("bad_wr0", wr_q[0], 16'h000D);
        chk("bad_wr1", wr_q[1], 16'h0003);
        chk("bad_wr2", wr_q[2], 16'h0000);
        chk("bad_err", error, 1);
        chk("bad_wcnt", word_count, 3);
        chk("bad_done", done_cnt - done_base, 1);

        // Address wrap at the top of memory
        mem[255] = 16'h0014;
        clear_mon();
        pulse_start(8'hFF);
        wait_done(200);
        chk("wrap_nwr", wr_q.size(), 2);
        chk("wrap_wr0", wr_q[0], 16'h0014);
        chk("wrap_wr1", wr_q[1], 16'h0000);
        chk("wrap_err", error, 1);
        chk("wrap_wcnt", word_count, 2);
        chk("wrap_nrd", rd_q.size(), 1);
        chk("wrap_rd0", rd_q[0], 8'hFF);

        // Asynchronous reset in WAIT of the third word, then a clean restart
        mem[8]  = 16'h000D; mem[9]  = 16'h0005; mem[10] = 16'h000D;
        mem[11] = 16'h0007; mem[12] = 16'h0014; mem[13] = 16'h0000;
        clear_mon();
        pulse_start(8'h08);
        wait_writes(2, 100);
        begin
            int k;
            k = 0;
            while (!mem_rd && k < 20) begin
                @(negedge clk); #1;
                k++;
            end
        end
        chk("pre_rst_rd", mem_rd, 1);
        @(posedge clk); #1;
        chk("pre_rst_addr", mem_addr, 8'h0A);
        chk("pre_rst_wcnt", word_count, 2);
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("arst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("arst_noterm", wr_q.size(), 2);
        clear_mon();
        pulse_start(8'h08);
        wait_done(200);
        check_prog1("restart");

        // Start pulses while busy are ignored
        mem[0] = 16'h000D; mem[1] = 16'h0005; mem[2] = 16'h000D;
        mem[3] = 16'h0007; mem[4] = 16'h0014; mem[5] = 16'h0000;
        clear_mon();
        pulse_start(8'h00);
        repeat (2) @(posedge clk);
        pulse_start(8'h40);
        repeat (5) @(posedge clk);
        pulse_start(8'h40);
        wait_done(200);
        check_prog1("busy_start");
        chk("busy_nrd", rd_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("busy_rd", rd_q[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
